// File: rtl/scp_run_pkg.sv
// Shared FSM state and halt-cause encodings for the run controller.
// Latency: n/a (constants only); backpressure: n/a.
package scp_run_pkg;

    typedef logic [2:0] run_state_t;

    localparam run_state_t ST_IDLE  = 3'd0;
    localparam run_state_t ST_RESET = 3'd1;
    localparam run_state_t ST_RUN   = 3'd2;
    localparam run_state_t ST_DRAIN = 3'd3;
    localparam run_state_t ST_DONE  = 3'd4;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_HALT    = 2'd1;
    localparam logic [1:0] CAUSE_LOOP    = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

endpackage

// File: rtl/scp_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
// Latency: 1 cycle from clr/en to cnt; backpressure: none, sticks at all-ones.
module scp_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/scp_run_ctrl.sv
// Run controller beside the core: holds core reset, counts cycles/retires, stops on halt, PC loop or timeout.
// Latency: all outputs registered, start -> core_rst low two edges later; backpressure: start ignored outside IDLE/DONE.
module scp_run_ctrl
    import scp_run_pkg::*;
#(
    parameter int RST_HOLD     = 25,
    parameter int MAX_CYCLES   = 3500,
    parameter int STALL_LIMIT  = 16,
    parameter int DRAIN_CYCLES = 4,
    parameter int PC_W         = 32,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PC_W-1:0]  pc,
    input  logic             retire,
    input  logic             halt_req,
    output logic             core_rst,
    output logic             running,
    output logic             done,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] cycles,
    output logic [CNT_W-1:0] retired,
    output logic [PC_W-1:0]  final_pc
);

    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam int DRN_W  = $clog2(DRAIN_CYCLES + 1);
    localparam int STL_W  = $clog2(STALL_LIMIT + 1);
    localparam int CMP_W  = (CNT_W > 32) ? CNT_W : 32;

    localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(RST_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [DRN_W-1:0]  DRN_END  = DRN_W'(DRAIN_CYCLES - 1);
    localparam logic [DRN_W-1:0]  DRN_ONE  = DRN_W'(1);
    localparam logic [STL_W-1:0]  STL_END  = STL_W'(STALL_LIMIT - 1);
    localparam logic [STL_W-1:0]  STL_ONE  = STL_W'(1);
    localparam logic [CMP_W-1:0]  CYC_END  = CMP_W'(MAX_CYCLES - 1);

    run_state_t        state_q,    state_d;
    logic [HOLD_W-1:0] hold_q,     hold_d;
    logic [DRN_W-1:0]  drain_q,    drain_d;
    logic [STL_W-1:0]  stall_q,    stall_d;
    logic [PC_W-1:0]   prev_pc_q,  prev_pc_d;
    logic              prev_vld_q, prev_vld_d;
    logic              core_rst_q, core_rst_d;
    logic              running_q,  running_d;
    logic              done_q,     done_d;
    logic [1:0]        cause_q,    cause_d;
    logic [PC_W-1:0]   final_pc_q, final_pc_d;

    logic cnt_clr;
    logic cyc_en;
    logic ret_en;
    logic pc_eq;
    logic cyc_last;

    // prev_vld suppresses the compare on the first RUN cycle, where prev_pc is stale.
    assign pc_eq    = prev_vld_q && (pc == prev_pc_q);
    assign cyc_last = (CMP_W'(cycles) == CYC_END);

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        drain_d    = drain_q;
        stall_d    = stall_q;
        prev_pc_d  = prev_pc_q;
        prev_vld_d = prev_vld_q;
        core_rst_d = core_rst_q;
        cause_d    = cause_q;
        final_pc_d = final_pc_q;
        cnt_clr    = 1'b0;
        cyc_en     = 1'b0;
        ret_en     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_RESET;
                    hold_d     = '0;
                    cause_d    = CAUSE_NONE;
                    final_pc_d = '0;
                    cnt_clr    = 1'b1;
                end
            end
            ST_RESET: begin
                core_rst_d = 1'b0;
                hold_d     = hold_q + HOLD_ONE;
                if (hold_q == HOLD_END) begin
                    state_d    = ST_RUN;
                    core_rst_d = 1'b1;
                    prev_vld_d = 1'b0;
                    stall_d    = '0;
                end
            end
            ST_RUN: begin
                cyc_en     = 1'b1;
                ret_en     = retire;
                prev_pc_d  = pc;
                prev_vld_d = 1'b1;
                stall_d    = pc_eq ? (stall_q + STL_ONE) : '0;
                if (halt_req) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                    cause_d = CAUSE_HALT;
                end else if (pc_eq && (stall_q == STL_END)) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                    cause_d = CAUSE_LOOP;
                end else if (cyc_last) begin
                    state_d    = ST_DONE;
                    cause_d    = CAUSE_TIMEOUT;
                    final_pc_d = pc;
                end
            end
            ST_DRAIN: begin
                cyc_en  = 1'b1;
                ret_en  = retire;
                drain_d = drain_q + DRN_ONE;
                if (drain_q == DRN_END) begin
                    state_d    = ST_DONE;
                    final_pc_d = pc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            drain_q    <= '0;
            stall_q    <= '0;
            prev_pc_q  <= '0;
            prev_vld_q <= 1'b0;
            core_rst_q <= 1'b0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            cause_q    <= CAUSE_NONE;
            final_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            drain_q    <= drain_d;
            stall_q    <= stall_d;
            prev_pc_q  <= prev_pc_d;
            prev_vld_q <= prev_vld_d;
            core_rst_q <= core_rst_d;
            running_q  <= running_d;
            done_q     <= done_d;
            cause_q    <= cause_d;
            final_pc_q <= final_pc_d;
        end
    end

    scp_sat_cnt #(.W(CNT_W)) u_cycles (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cyc_en),
        .cnt (cycles)
    );

    scp_sat_cnt #(.W(CNT_W)) u_retired (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (ret_en),
        .cnt (retired)
    );

    assign core_rst   = core_rst_q;
    assign running    = running_q;
    assign done       = done_q;
    assign halt_cause = cause_q;
    assign final_pc   = final_pc_q;

endmodule

// File: tb/tb_scp_run_ctrl.sv
// Scenario bench for scp_run_ctrl: randomized retire/pc streams against per-scenario expected totals.
module tb_scp_run_ctrl;

    localparam int RST_HOLD     = 25;
    localparam int MAX_CYCLES   = 3500;
    localparam int STALL_LIMIT  = 16;
    localparam int DRAIN_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, retire = 1'b0, halt_req = 1'b0;
    logic [31:0] pc = 32'd0;
    logic        core_rst, running, done;
    logic [1:0]  halt_cause;
    logic [31:0] cycles, retired, final_pc;

    logic        start_s = 1'b0, retire_s = 1'b0, halt_s = 1'b0;
    logic [31:0] pc_s = 32'd0;
    logic        core_rst_s, running_s, done_s;
    logic [1:0]  cause_s;
    logic [3:0]  cycles_s, retired_s;
    logic [31:0] final_pc_s;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    scp_run_ctrl #(
        .RST_HOLD(RST_HOLD), .MAX_CYCLES(MAX_CYCLES), .STALL_LIMIT(STALL_LIMIT),
        .DRAIN_CYCLES(DRAIN_CYCLES), .PC_W(32), .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pc(pc), .retire(retire), .halt_req(halt_req),
        .core_rst(core_rst), .running(running), .done(done), .halt_cause(halt_cause),
        .cycles(cycles), .retired(retired), .final_pc(final_pc)
    );

    scp_run_ctrl #(
        .RST_HOLD(RST_HOLD), .MAX_CYCLES(20), .STALL_LIMIT(STALL_LIMIT),
        .DRAIN_CYCLES(DRAIN_CYCLES), .PC_W(32), .CNT_W(4)
    ) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .pc(pc_s), .retire(retire_s), .halt_req(halt_s),
        .core_rst(core_rst_s), .running(running_s), .done(done_s), .halt_cause(cause_s),
        .cycles(cycles_s), .retired(retired_s), .final_pc(final_pc_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start and verify the reset window: low after edge k+1, RUN at edge k+1+RST_HOLD.
    task automatic start_run(input bit from_done);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_chk++; if (core_rst !== from_done) $display("FAIL start_edge_core_rst got %b exp %b", core_rst, from_done); else n_pass++;
        n_chk++; if ({done, halt_cause, cycles, retired} !== 35'd0)
            $display("FAIL start_clear got done=%b cause=%0d cycles=%0d retired=%0d exp all 0", done, halt_cause, cycles, retired);
        else n_pass++;
        tick();
        n_chk++; if (core_rst !== 1'b0) $display("FAIL rst_low_first got %b exp 0", core_rst); else n_pass++;
        repeat (RST_HOLD - 1) tick();
        n_chk++; if ({core_rst, running} !== 2'b00) $display("FAIL rst_low_last got core_rst=%b running=%b exp 0 0", core_rst, running); else n_pass++;
        tick();
        n_chk++; if ({core_rst, running} !== 2'b11) $display("FAIL run_entry got core_rst=%b running=%b exp 1 1", core_rst, running); else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        n_chk++; if ({core_rst, running, done, halt_cause} !== 5'd0)
            $display("FAIL reset_ctrl got core_rst=%b running=%b done=%b cause=%0d exp 0", core_rst, running, done, halt_cause);
        else n_pass++;
        n_chk++; if ({cycles, retired, final_pc} !== 96'd0)
            $display("FAIL reset_counts got cycles=%0d retired=%0d final_pc=%h exp 0", cycles, retired, final_pc);
        else n_pass++;
        rst = 1'b1;
        repeat (2) tick();
        n_chk++; if ({core_rst, running, done} !== 3'b000) $display("FAIL idle_hold got %b%b%b exp 000", core_rst, running, done); else n_pass++;
    endtask

    task automatic test_timeout();
        int exp_ret = 0;
        logic [31:0] last_pc = 32'd0;
        start_run(1'b0);
        for (int i = 1; i <= MAX_CYCLES; i++) begin
            retire = 1'($urandom % 2);
            pc = 32'h1000 + 32'(4 * i);
            last_pc = pc;
            exp_ret += int'(retire);
            tick();
            if (i == MAX_CYCLES - 1) begin
                n_chk++; if ({running, done} !== 2'b10 || cycles !== 32'(MAX_CYCLES - 1))
                    $display("FAIL timeout_pre got running=%b done=%b cycles=%0d exp 1 0 %0d", running, done, cycles, MAX_CYCLES - 1);
                else n_pass++;
            end
        end
        n_chk++; if ({running, done, halt_cause} !== 4'b0111) $display("FAIL timeout_done got running=%b done=%b cause=%0d exp 0 1 3", running, done, halt_cause); else n_pass++;
        n_chk++; if (cycles !== 32'(MAX_CYCLES)) $display("FAIL timeout_cycles got %0d exp %0d", cycles, MAX_CYCLES); else n_pass++;
        n_chk++; if (retired !== 32'(exp_ret)) $display("FAIL timeout_retired got %0d exp %0d", retired, exp_ret); else n_pass++;
        n_chk++; if (final_pc !== last_pc) $display("FAIL timeout_final_pc got %h exp %h", final_pc, last_pc); else n_pass++;
        retire = 1'b1;
        repeat (3) tick();
        retire = 1'b0;
        n_chk++; if (cycles !== 32'(MAX_CYCLES) || retired !== 32'(exp_ret) || core_rst !== 1'b1 || done !== 1'b1)
            $display("FAIL done_hold got cycles=%0d retired=%0d core_rst=%b done=%b exp %0d %0d 1 1", cycles, retired, core_rst, done, MAX_CYCLES, exp_ret);
        else n_pass++;
    endtask

    // Halt at RUN edge h; start pulses mid-run and mid-drain must be ignored.
    task automatic run_halt(input int h, input bit rnd, input bit from_done);
        int exp_ret = 0;
        int last = h + DRAIN_CYCLES;
        start_run(from_done);
        for (int i = 1; i <= last; i++) begin
            retire   = rnd ? 1'($urandom % 2) : (i % 2 == 0);
            halt_req = (i == h);
            start    = (i == h / 2) || (i == h + 2);
            pc       = 32'h2000 + 32'(4 * i);
            exp_ret += int'(retire);
            tick();
            if (i == h) begin
                n_chk++; if ({running, done, core_rst} !== 3'b001) $display("FAIL halt_drain got running=%b done=%b core_rst=%b exp 0 0 1", running, done, core_rst); else n_pass++;
            end
            if (i == last - 1) begin
                n_chk++; if (done !== 1'b0) $display("FAIL halt_drain_len got done=%b exp 0", done); else n_pass++;
            end
        end
        halt_req = 1'b0; start = 1'b0; retire = 1'b0;
        n_chk++; if ({done, halt_cause} !== 3'b101) $display("FAIL halt_done got done=%b cause=%0d exp 1 1", done, halt_cause); else n_pass++;
        n_chk++; if (cycles !== 32'(last)) $display("FAIL halt_cycles got %0d exp %0d", cycles, last); else n_pass++;
        n_chk++; if (retired !== 32'(exp_ret)) $display("FAIL halt_retired got %0d exp %0d", retired, exp_ret); else n_pass++;
        n_chk++; if (final_pc !== 32'h2000 + 32'(4 * last)) $display("FAIL halt_final_pc got %h exp %h", final_pc, 32'h2000 + 32'(4 * last)); else n_pass++;
    endtask

    task automatic test_pc_loop();
        int s = 30 + int'($urandom_range(0, 30));
        int drain_at = s + STALL_LIMIT;
        int last = drain_at + DRAIN_CYCLES;
        int exp_ret = 0;
        start_run(1'b1);
        for (int i = 1; i <= last; i++) begin
            if (i >= s)                pc = 32'h40;
            else if (i >= 6 && i <= 21) pc = 32'h80;
            else                       pc = 32'h3000 + 32'(4 * i);
            retire = 1'($urandom % 2);
            exp_ret += int'(retire);
            tick();
            if (i == 21) begin
                n_chk++; if (running !== 1'b1) $display("FAIL loop_short_plateau got running=%b exp 1", running); else n_pass++;
            end
            if (i == drain_at - 1) begin
                n_chk++; if (running !== 1'b1) $display("FAIL loop_pre got running=%b exp 1", running); else n_pass++;
            end
            if (i == drain_at) begin
                n_chk++; if ({running, done} !== 2'b00) $display("FAIL loop_drain got running=%b done=%b exp 0 0", running, done); else n_pass++;
            end
        end
        retire = 1'b0;
        n_chk++; if ({done, halt_cause} !== 3'b110) $display("FAIL loop_done got done=%b cause=%0d exp 1 2", done, halt_cause); else n_pass++;
        n_chk++; if (final_pc !== 32'h40) $display("FAIL loop_final_pc got %h exp 40", final_pc); else n_pass++;
        n_chk++; if (cycles !== 32'(last) || retired !== 32'(exp_ret))
            $display("FAIL loop_counts got cycles=%0d retired=%0d exp %0d %0d", cycles, retired, last, exp_ret);
        else n_pass++;
    endtask

    task automatic test_halt_vs_timeout();
        start_run(1'b1);
        for (int i = 1; i <= MAX_CYCLES + DRAIN_CYCLES; i++) begin
            halt_req = (i == MAX_CYCLES);
            pc = 32'h5000 + 32'(4 * i);
            tick();
            if (i == MAX_CYCLES) begin
                n_chk++; if ({running, done, core_rst} !== 3'b001 || cycles !== 32'(MAX_CYCLES))
                    $display("FAIL tie_drain got running=%b done=%b core_rst=%b cycles=%0d exp 0 0 1 %0d", running, done, core_rst, cycles, MAX_CYCLES);
                else n_pass++;
            end
        end
        halt_req = 1'b0;
        n_chk++; if ({done, halt_cause} !== 3'b101) $display("FAIL tie_cause got done=%b cause=%0d exp 1 1", done, halt_cause); else n_pass++;
        n_chk++; if (cycles !== 32'(MAX_CYCLES + DRAIN_CYCLES)) $display("FAIL tie_cycles got %0d exp %0d", cycles, MAX_CYCLES + DRAIN_CYCLES); else n_pass++;
    endtask

    task automatic test_midrun_reset();
        start_run(1'b1);
        for (int i = 1; i <= 50; i++) begin
            retire = 1'b1;
            pc = 32'h6000 + 32'(4 * i);
            tick();
        end
        #3 rst = 1'b0;
        #1;
        n_chk++; if ({core_rst, running, done, halt_cause} !== 5'd0)
            $display("FAIL async_rst_ctrl got core_rst=%b running=%b done=%b cause=%0d exp 0", core_rst, running, done, halt_cause);
        else n_pass++;
        n_chk++; if ({cycles, retired, final_pc} !== 96'd0)
            $display("FAIL async_rst_counts got cycles=%0d retired=%0d final_pc=%h exp 0", cycles, retired, final_pc);
        else n_pass++;
        #1 rst = 1'b1;
        retire = 1'b0;
        repeat (3) tick();
        n_chk++; if ({core_rst, running, done, cycles} !== 35'd0)
            $display("FAIL post_rst_idle got core_rst=%b running=%b done=%b cycles=%0d exp 0", core_rst, running, done, cycles);
        else n_pass++;
        run_halt(10, 1'b1, 1'b0);
    endtask

    task automatic test_saturate();
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        repeat (RST_HOLD + 1) tick();
        n_chk++; if (running_s !== 1'b1) $display("FAIL sat_run got running=%b exp 1", running_s); else n_pass++;
        retire_s = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            pc_s = 32'h7000 + 32'(4 * i);
            tick();
        end
        n_chk++; if (cycles_s !== 4'hF || retired_s !== 4'hF) $display("FAIL sat_counts got cycles=%0d retired=%0d exp 15 15", cycles_s, retired_s); else n_pass++;
        halt_s = 1'b1;
        tick();
        halt_s = 1'b0;
        repeat (DRAIN_CYCLES) tick();
        retire_s = 1'b0;
        n_chk++; if ({done_s, cause_s} !== 3'b101 || cycles_s !== 4'hF)
            $display("FAIL sat_done got done=%b cause=%0d cycles=%0d exp 1 1 15", done_s, cause_s, cycles_s);
        else n_pass++;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        n_chk++; if ({done_s, cycles_s, retired_s, cause_s} !== 11'd0)
            $display("FAIL sat_restart got done=%b cycles=%0d retired=%0d cause=%0d exp 0", done_s, cycles_s, retired_s, cause_s);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_timeout();
        run_halt(100, 1'b0, 1'b1);
        run_halt(40 + int'($urandom_range(0, 160)), 1'b1, 1'b1);
        test_pc_loop();
        test_halt_vs_timeout();
        test_midrun_reset();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
